// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: Y86-64 data-memory initiator with req/ack handshake, range check and timeout
module dmem_access_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic is_wr, is_rd, bad;
    logic [63:0] addr, wdata;
    assign ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == DONE;
    // Decode the operation: ret/popq address through valA, call writes the return address
    always_comb begin
        is_wr = icode == 4'h4 || icode == 4'h8 || icode == 4'hA;
        is_rd = icode == 4'h5 || icode == 4'h9 || icode == 4'hB;
        addr = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
        wdata = icode == 4'h8 ? valP : valA;
        bad = addr >= 64'(MEM_WORDS);
    end
    // Control FSM with registered request fields, read data and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            valM <= '0;
            dmem_error <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dmem_error <= 1'b0;
                    cnt <= '0;
                    if (!(is_wr || is_rd)) begin
                        state <= DONE;
                    end else if (bad) begin
                        dmem_error <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we <= is_wr;
                        mem_addr <= addr;
                        mem_wdata <= wdata;
                        state <= REQ;
                    end
                end
                REQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (!mem_we) valM <= mem_rdata;
                    state <= DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    mem_req <= 1'b0;
                    dmem_error <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with a memory responder for dmem_access_ctrl
module tb_dmem_access_ctrl;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0] icode = '0;
    logic [63:0] valA = '0, valE = '0, valP = '0;
    logic ready, busy, done, dmem_error, mem_req, mem_we;
    logic [63:0] valM, mem_addr, mem_wdata;
    logic mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    int n_chk = 0, n_fail = 0;
    int cur_ack = 0, req_cnt = 0, last_len = 0;
    logic [64:0] sb_q[$];
    logic [128:0] req_q[$];
    logic [63:0] mem_model[logic [63:0]];

    dmem_access_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode), .valA(valA), .valE(valE),
        .valP(valP), .ready(ready), .busy(busy), .done(done), .valM(valM),
        .dmem_error(dmem_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pops one expected {dmem_error, valM}
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                logic [64:0] e;
                e = sb_q.pop_front();
                chk("done_err", {63'd0, dmem_error}, {63'd0, e[64]});
                chk("done_valM", valM, e[63:0]);
            end
        end
    end

    // Memory responder: checks request fields on the first REQ cycle, acks on cycle cur_ack
    always @(negedge clk) begin
        if (mem_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
                if (req_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
                end else begin
                    logic [128:0] r;
                    r = req_q.pop_front();
                    chk("req_we", {63'd0, mem_we}, {63'd0, r[128]});
                    chk("req_addr", mem_addr, r[127:64]);
                    if (r[128]) chk("req_wdata", mem_wdata, r[63:0]);
                end
            end
            mem_ack = cur_ack != 0 && req_cnt == cur_ack;
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'd0;
            if (mem_ack && mem_we) mem_model[mem_addr] = mem_wdata;
        end else begin
            if (req_cnt > 0) last_len = req_cnt;
            req_cnt = 0;
            mem_ack = 1'b0;
        end
    end

    task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input int ack, input int exp_lat, input int exp_len,
                         input logic exp_we, input logic [63:0] exp_addr, input logic [63:0] exp_wd,
                         input logic exp_err, input logic [63:0] exp_valm, input bit glitch);
        int lat;
        cur_ack = ack;
        sb_q.push_back({exp_err, exp_valm});
        if (exp_len > 0) req_q.push_back({exp_we, exp_addr, exp_wd});
        chk("ready_before", {63'd0, ready}, 64'd1);
        icode = ic; valA = a; valE = e; valP = p; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = glitch && lat == 1;
            if (start) begin icode = 4'h4; valE = 64'd999; end
        end while (!done && lat < 40);
        start = 1'b0;
        if (!done) $display("FAIL op_timeout: got no done after %0d cycles expected done", lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        if (exp_len > 0) chk("req_len", 64'(last_len), 64'(exp_len));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_err", {63'd0, dmem_error}, 64'd0);
        chk("rst_req", {62'd0, mem_req, mem_we}, 64'd0);
        chk("rst_addr", mem_addr | mem_wdata, 64'd0);
        reset = 1'b0;
        mem_model[64'd32] = 64'd88;
        @(negedge clk);
        do_op(4'h4, 64'd24, 64'd7, 64'd0, 3, 4, 3, 1'b1, 64'd7, 64'd24, 1'b0, 64'd0, 0);
        do_op(4'h5, 64'd0, 64'd32, 64'd0, 1, 2, 1, 1'b0, 64'd32, 64'd0, 1'b0, 64'd88, 0);
        do_op(4'h8, 64'd0, 64'd47, 64'h100, 1, 2, 1, 1'b1, 64'd47, 64'h100, 1'b0, 64'd88, 0);
        do_op(4'hB, 64'd47, 64'd0, 64'd0, 1, 2, 1, 1'b0, 64'd47, 64'd0, 1'b0, 64'h100, 0);
        do_op(4'h5, 64'd0, 64'd1024, 64'd0, 1, 1, 0, 1'b0, 64'd0, 64'd0, 1'b1, 64'h100, 0);
        do_op(4'h1, 64'd0, 64'd0, 64'd0, 1, 1, 0, 1'b0, 64'd0, 64'd0, 1'b0, 64'h100, 0);
        do_op(4'h4, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1, 0, 1'b0, 64'd0, 64'd0, 1'b1, 64'h100, 0);
        do_op(4'h9, 64'd5, 64'd0, 64'd0, 0, 17, 16, 1'b0, 64'd5, 64'd0, 1'b1, 64'h100, 0);
        do_op(4'hA, 64'd99, 64'd3, 64'd0, 2, 3, 2, 1'b1, 64'd3, 64'd99, 1'b0, 64'h100, 0);
        do_op(4'hB, 64'd3, 64'd0, 64'd0, 3, 4, 3, 1'b0, 64'd3, 64'd0, 1'b0, 64'd99, 1);
        do_op(4'h5, 64'd0, 64'd1023, 64'd0, 1, 2, 1, 1'b0, 64'd1023, 64'd0, 1'b0, 64'd0, 0);
        cur_ack = 0;
        req_q.push_back({1'b0, 64'd10, 64'd0});
        icode = 4'h5; valE = 64'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req", {63'd0, mem_req}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        do_op(4'h1, 64'd0, 64'd0, 64'd0, 1, 1, 0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory interface for the Y86-64 processor.
- Takes a memory-stage operation (icode, valA, valE, valP) and decodes it into read or write requests to a multi-cycle data memory over a req/ack handshake.
- Returns valM and a completion pulse to the pipeline, with stall (busy) and memory-error reporting.
- Sits between execute/memory stage control and the data memory array.

Parameters:
- MEM_WORDS, 1024, number of 64-bit data words; valid addresses are 0..MEM_WORDS-1.
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before an error is raised.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operation valid; accepted only when ready=1.
- icode  input  4  instruction code of the operation.
- valA  input  64  source data, or stack address for ret/popq.
- valE  input  64  computed address for rmmovq/mrmovq/call/pushq.
- valP  input  64  return address written by call.
- ready  output  1  high in IDLE; block can accept start.
- busy  output  1  high while an accepted operation is in flight (pipeline stall).
- done  output  1  one-cycle pulse when the operation completes.
- valM  output  64  read data, valid from the done cycle until the next done.
- dmem_error  output  1  qualifies done; high means bad address or timeout.
- mem_req  output  1  request to data memory.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  64  word address; valid while mem_req=1.
- mem_wdata  output  64  write data; valid while mem_req=1 and mem_we=1.
- mem_ack  input  1  memory completion; sampled only while mem_req=1.
- mem_rdata  input  64  read data; valid in the mem_ack cycle of a read.

Behaviour:
- Reset:
  - state=IDLE, ready=1, busy=0, done=0, valM=0, dmem_error=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0.
  - Reset mid-transaction abandons it: mem_req drops the next cycle and no done is produced.
- Decode, latched on an accepted start:
  - 4 rmmovq: write valA to addr valE.
  - 5 mrmovq: read addr valE.
  - 8 call: write valP to addr valE.
  - 9 ret: read addr valA.
  - A pushq: write valA to addr valE.
  - B popq: read addr valA.
  - Any other icode: no memory access.
- States: IDLE, REQ, DONE.
- IDLE, start=1:
  - No-access icode -> DONE; dmem_error=0; valM holds its previous value.
  - Address >= MEM_WORDS (unsigned) -> DONE with dmem_error=1; no request is issued.
  - Otherwise -> REQ; mem_req/mem_we/mem_addr/mem_wdata are registered, so mem_req is high in the cycle after start.
- REQ:
  - mem_req and all request fields are held stable until the ack.
  - mem_ack=1 -> DONE. On a read, valM <= mem_rdata. mem_req is low in the next cycle.
  - Counter increments each REQ cycle without an ack. Reaching TIMEOUT -> DONE with dmem_error=1; mem_req is dropped and valM is unchanged.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Status outputs: busy = (state != IDLE); ready = (state == IDLE).
- Latency:
  - Access with ack in the first REQ cycle: start at cycle N, mem_req at N+1, done at N+2.
  - No-access icode: done at N+1.
- start while busy is ignored; the operation is not queued. Upstream must hold its operation until ready.
- mem_ack while mem_req=0 is ignored.
- start is accepted in the same cycle that DONE returns to IDLE only if ready=1. Since ready=0 in DONE, the minimum spacing between accepted starts is 2 cycles.
- dmem_error is meaningful only when done=1; it is cleared when the next operation is accepted.
- Addresses are compared as unsigned 64-bit, so negative valE values are out of range.

Test Plan:
- Reset, then start icode=4, valA=24, valE=7; memory acks on the 3rd REQ cycle -> mem_req high for exactly 3 cycles with we=1, addr=7, wdata=24; done 1 cycle later; dmem_error=0.
- Start icode=5, valE=32; ack on the first REQ cycle with mem_rdata=88 -> done at start+2, valM=88, mem_we=0.
- Start icode=8, valE=47, valP=0x100, then icode=B, valA=47 with a memory model -> write of 0x100, then a read returning valM=0x100.
- Start icode=5, valE=1024 -> no mem_req; done at start+1 with dmem_error=1. Start icode=1 (nop) -> done at start+1, dmem_error=0, valM unchanged.
- Start icode=9, valA=5 with ack never asserted -> mem_req high for 16 cycles, then done with dmem_error=1; a further start is accepted afterwards.
- Assert reset while in REQ -> mem_req=0 and busy=0 the next cycle; no done. Pulse start while busy=1 -> ignored, with only one done produced.
